// File: rtl/exec_sequencer_if.sv
// Bundles the decode, execution-unit and writeback signals of exec_sequencer.
// The sequencer connects through the slave modport; its environment uses master.
interface exec_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [15:0] in_src1;
    logic [15:0] in_src2;
    logic [15:0] in_imm;
    logic [2:0]  in_rd;

    logic [3:0]  eu_opcode;
    logic [15:0] eu_src1;
    logic [15:0] eu_src2;
    logic [15:0] eu_imm;
    logic [15:0] eu_result;
    logic        eu_zero;
    logic        eu_carry;
    logic        eu_div_done;

    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        wb_err;

    logic        zero_flag;
    logic        carry_flag;
    logic        busy;

    modport master (
        output in_valid, in_opcode, in_src1, in_src2, in_imm, in_rd,
        output eu_result, eu_zero, eu_carry, eu_div_done,
        output wb_ready,
        input  in_ready, eu_opcode, eu_src1, eu_src2, eu_imm,
        input  wb_valid, wb_rd, wb_data, wb_err, zero_flag, carry_flag, busy
    );

    modport slave (
        input  in_valid, in_opcode, in_src1, in_src2, in_imm, in_rd,
        input  eu_result, eu_zero, eu_carry, eu_div_done,
        input  wb_ready,
        output in_ready, eu_opcode, eu_src1, eu_src2, eu_imm,
        output wb_valid, wb_rd, wb_data, wb_err, zero_flag, carry_flag, busy
    );
endinterface

// File: rtl/exec_sequencer.sv
// Execute-stage controller: accept one op, wait for the execution unit, hand result to writeback.
// Define EXEC_SEQ_TIMEOUT_EN to enable the divide watchdog (wb_err, DIV_TIMEOUT).
module exec_sequencer #(
    parameter logic [3:0] DIV_OPCODE  = 4'd7,
    parameter int         DIV_TIMEOUT = 16
) (
    input logic             clk,
    input logic             rst_n,
    exec_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, EXEC, DIV_WAIT, WB} state_t;

    state_t      state, state_nxt;
    logic        accept, capture, commit;
    logic [3:0]  opcode_q;
    logic [15:0] src1_q, src2_q, imm_q, data_q;
    logic [2:0]  rd_q;
    logic        pend_zero_q, pend_carry_q, zero_q, carry_q;

    if (DIV_TIMEOUT < 2 || DIV_TIMEOUT > 255) begin : g_bad_timeout
        $error("exec_sequencer: DIV_TIMEOUT must be in 2..255");
    end

`ifdef EXEC_SEQ_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(DIV_TIMEOUT - 1);
    logic [7:0] cnt_q;
    logic       err_q, timeout, cnt_clr, cnt_inc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        commit    = 1'b0;
`ifdef EXEC_SEQ_TIMEOUT_EN
        timeout   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
`endif
        unique case (state)
            IDLE: if (bus.in_valid) begin
                accept    = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: if (opcode_q != DIV_OPCODE) begin
                capture   = 1'b1;
                state_nxt = WB;
            end else begin
`ifdef EXEC_SEQ_TIMEOUT_EN
                cnt_clr   = 1'b1;
`endif
                state_nxt = DIV_WAIT;
            end
            // A done flag on the final count still yields the real result.
            DIV_WAIT: if (bus.eu_div_done) begin
                capture   = 1'b1;
                state_nxt = WB;
            end
`ifdef EXEC_SEQ_TIMEOUT_EN
            else if (cnt_q == TIMEOUT_LAST) begin
                timeout   = 1'b1;
                state_nxt = WB;
            end else begin
                cnt_inc   = 1'b1;
            end
`endif
            WB: if (bus.wb_ready) begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q     <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            imm_q        <= '0;
            rd_q         <= '0;
            data_q       <= '0;
            pend_zero_q  <= 1'b0;
            pend_carry_q <= 1'b0;
            zero_q       <= 1'b0;
            carry_q      <= 1'b0;
        end else begin
            if (accept) begin
                opcode_q <= bus.in_opcode;
                src1_q   <= bus.in_src1;
                src2_q   <= bus.in_src2;
                imm_q    <= bus.in_imm;
                rd_q     <= bus.in_rd;
            end
            if (capture) begin
                data_q       <= bus.eu_result;
                pend_zero_q  <= bus.eu_zero;
                pend_carry_q <= bus.eu_carry;
            end
`ifdef EXEC_SEQ_TIMEOUT_EN
            if (timeout) begin
                data_q       <= 16'hFFFF;
                pend_zero_q  <= 1'b0;
                pend_carry_q <= 1'b1;
            end
`endif
            if (commit) begin
                zero_q  <= pend_zero_q;
                carry_q <= pend_carry_q;
            end
        end
    end

`ifdef EXEC_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + 8'd1;
            if (capture)      err_q <= 1'b0;
            else if (timeout) err_q <= 1'b1;
        end
    end
    assign bus.wb_err = err_q;
`else
    assign bus.wb_err = 1'b0;
`endif

    // in_ready is held low while reset is asserted, not just outside IDLE.
    assign bus.in_ready   = (state == IDLE) && rst_n;
    assign bus.busy       = (state != IDLE);
    assign bus.wb_valid   = (state == WB);
    assign bus.wb_data    = data_q;
    assign bus.wb_rd      = rd_q;
    assign bus.eu_opcode  = opcode_q;
    assign bus.eu_src1    = src1_q;
    assign bus.eu_src2    = src2_q;
    assign bus.eu_imm     = imm_q;
    assign bus.zero_flag  = zero_q;
    assign bus.carry_flag = carry_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: table vectors, hand sequences and random ops.
// The bench also plays the execution unit through a behavioural ALU function.
module tb_exec_sequencer;
    localparam logic [3:0] DIV_OP  = 4'd7;
    localparam int         TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic div_done;
    int   errors = 0;
    int   checks = 0;
    logic mz, mc;

    exec_sequencer_if bus();

    exec_sequencer #(.DIV_OPCODE(DIV_OP), .DIV_TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Behavioural execution unit: returns {carry, zero, result}.
    function automatic logic [17:0] alu(input logic [3:0] op, input logic [15:0] a, b, im);
        logic [16:0] t;
        case (op)
            4'd0:    t = {1'b0, a} + {1'b0, b};
            4'd1:    t = {1'b0, a} - {1'b0, b};
            4'd2:    t = {1'b0, a & b};
            4'd3:    t = {1'b0, a} + {1'b0, im};
            DIV_OP:  t = (b == 16'd0) ? {1'b1, 16'hFFFF} : {1'b0, a / b};
            default: t = {1'b0, a ^ b};
        endcase
        return {t[16], (t[15:0] == 16'd0), t[15:0]};
    endfunction

    assign {bus.eu_carry, bus.eu_zero, bus.eu_result} = alu(bus.eu_opcode, bus.eu_src1, bus.eu_src2, bus.eu_imm);
    assign bus.eu_div_done = div_done;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [15:0] s1, s2, im, input logic [2:0] rd,
                          input int stall, input int k, input logic [15:0] ed, input logic ez, ec, ee,
                          input int elat, input string nm);
        int lat;
        check({nm, " in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_src1   = s1;
        bus.in_src2   = s2;
        bus.in_imm    = im;
        bus.in_rd     = rd;
        bus.wb_ready  = 1'b0;
        @(posedge clk); @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_src1   = 16'($urandom);
        bus.in_opcode = 4'($urandom);
        check({nm, " eu_opcode"}, 32'(bus.eu_opcode), 32'(op));
        check({nm, " eu_operands"}, {bus.eu_src1, bus.eu_src2}, {s1, s2});
        check({nm, " eu_imm"}, 32'(bus.eu_imm), 32'(im));
        check({nm, " busy"}, 32'(bus.busy), 32'd1);
        lat = 1;
        while (!bus.wb_valid && lat < 64) begin
            div_done = (op == DIV_OP && k >= 0 && lat == k + 2) ? 1'b1 : 1'b0;
            @(posedge clk); @(negedge clk);
            div_done = 1'b0;
            lat++;
        end
        check({nm, " latency"}, 32'(lat), 32'(elat));
        check({nm, " wb_data"}, 32'(bus.wb_data), 32'(ed));
        check({nm, " wb_rd"}, 32'(bus.wb_rd), 32'(rd));
        check({nm, " wb_err"}, 32'(bus.wb_err), 32'(ee));
        check({nm, " flags_before"}, {bus.zero_flag, bus.carry_flag}, {mz, mc});
        for (int i = 0; i < stall; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_opcode = 4'($urandom);
            bus.in_src1   = 16'($urandom);
            @(posedge clk); @(negedge clk);
            check({nm, " stall_hold"}, {bus.wb_valid, bus.in_ready, bus.wb_rd, bus.wb_data, bus.eu_src1},
                  {1'b1, 1'b0, rd, ed, s1});
            check({nm, " stall_flags"}, {bus.zero_flag, bus.carry_flag}, {mz, mc});
        end
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.wb_ready = 1'b0;
        check({nm, " after_hs"}, {bus.wb_valid, bus.busy}, 2'b00);
        check({nm, " flags_after"}, {bus.zero_flag, bus.carry_flag}, {ez, ec});
        mz = ez;
        mc = ec;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] s1, s2, im;
        logic [2:0]  rd;
        int          stall;
        logic [15:0] d;
        logic        z, c;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [17:0] r;
        logic [3:0]  op;
        logic [15:0] s1, s2, im;
        int          k, st;

        tbl[0] = '{4'd0, 16'h0001, 16'hFFFF, 16'h0000, 3'd3, 0, 16'h0000, 1'b1, 1'b1};
        tbl[1] = '{4'd0, 16'h1234, 16'h0001, 16'h0000, 3'd5, 5, 16'h1235, 1'b0, 1'b0};
        tbl[2] = '{4'd1, 16'h0005, 16'h0007, 16'h0000, 3'd1, 1, 16'hFFFE, 1'b0, 1'b1};
        tbl[3] = '{4'd2, 16'hF0F0, 16'h0F0F, 16'h0000, 3'd7, 0, 16'h0000, 1'b1, 1'b0};
        tbl[4] = '{4'd3, 16'h8000, 16'h1111, 16'h8000, 3'd2, 2, 16'h0000, 1'b1, 1'b1};
        tbl[5] = '{4'd5, 16'h00FF, 16'h0F0F, 16'h0000, 3'd4, 0, 16'h0FF0, 1'b0, 1'b0};

        rst_n = 1'b0;
        div_done = 1'b0;
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b0;
        bus.in_opcode = '0;
        bus.in_src1 = '0;
        bus.in_src2 = '0;
        bus.in_imm = '0;
        bus.in_rd = '0;
        mz = 1'b0;
        mc = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ctrl", {bus.in_ready, bus.busy, bus.wb_valid, bus.wb_err, bus.zero_flag, bus.carry_flag}, 6'b0);
        check("reset data", {bus.eu_opcode, bus.eu_src1, bus.wb_rd, bus.wb_data}, 39'b0);
        rst_n = 1'b1;
        #1;
        check("reset release in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        foreach (tbl[i])
            run_op(tbl[i].op, tbl[i].s1, tbl[i].s2, tbl[i].im, tbl[i].rd, tbl[i].stall, -1,
                   tbl[i].d, tbl[i].z, tbl[i].c, 1'b0, 2, $sformatf("vec%0d", i));

        // Divide with done four cycles into DIV_WAIT: 100/7 = 14.
        run_op(DIV_OP, 16'd100, 16'd7, 16'h0, 3'd6, 1, 4, 16'd14, 1'b0, 1'b0, 1'b0, 7, "div_done");
        // Done first seen on the final watchdog count: real result wins.
        run_op(DIV_OP, 16'd9, 16'd9, 16'h0, 3'd2, 0, TIMEOUT - 1, 16'd1, 1'b0, 1'b0, 1'b0, TIMEOUT + 2, "div_coincide");
`ifdef EXEC_SEQ_TIMEOUT_EN
        run_op(DIV_OP, 16'd50, 16'd5, 16'h0, 3'd1, 2, -1, 16'hFFFF, 1'b0, 1'b1, 1'b1, TIMEOUT + 2, "div_timeout");
`else
        run_op(DIV_OP, 16'd50, 16'd5, 16'h0, 3'd1, 2, 40, 16'd10, 1'b0, 1'b0, 1'b0, 43, "div_long_wait");
`endif

        // Reset in the middle of DIV_WAIT after flags were set to 1/1.
        run_op(4'd0, 16'h0001, 16'hFFFF, 16'h0, 3'd0, 0, -1, 16'h0000, 1'b1, 1'b1, 1'b0, 2, "pre_reset_add");
        bus.in_valid = 1'b1;
        bus.in_opcode = DIV_OP;
        bus.in_src1 = 16'h00AA;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst ctrl", {bus.in_ready, bus.busy, bus.wb_valid, bus.zero_flag, bus.carry_flag}, 5'b0);
        check("midrst data", {bus.eu_src1, bus.wb_data}, 32'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst in_ready", 32'(bus.in_ready), 32'd1);
        mz = 1'b0;
        mc = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 7));
            s1 = 16'($urandom);
            s2 = (n % 5 == 0) ? 16'd0 : 16'($urandom_range(0, 300));
            im = 16'($urandom);
            k  = $urandom_range(0, 12);
            st = $urandom_range(0, 3);
            r  = alu(op, s1, s2, im);
            run_op(op, s1, s2, im, 3'($urandom), st, k, r[15:0], r[16], r[17], 1'b0,
                   (op == DIV_OP) ? k + 3 : 2, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
